li_credit_pipe_wrapper: RTL and testbench

//   Generic latency-insensitive ready/valid wrapper for any fixed-latency,
//   non-stallable pipelined core, such as the FP adder variants.
//   - Issues operand pairs to the core and tracks them through the core with a valid shift register.
//   - Catches results in an output FIFO sized by credits, so the core never stalls.
//   - Back-pressure from out_ready stalls only acceptance (in_ready), never the core pipeline.
//

---
 rtl/li_credit_pipe_wrapper_if.sv | 33 +++
 rtl/li_credit_pipe_wrapper.sv | 122 ++++++++++++
 tb/tb_li_credit_pipe_wrapper.sv | 339 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/li_credit_pipe_wrapper_if.sv
// Ready/valid bundle between the credit wrapper, its producer,
// its consumer and the fixed-latency core it drives.
interface li_credit_pipe_wrapper_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
);
  localparam int OW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] core_a;
  logic [WIDTH-1:0] core_b;
  logic             core_issue;
  logic [WIDTH-1:0] core_result;
  logic [OW-1:0]    occupancy;

  modport slave (
    input  in_a, in_b, in_valid, out_ready, core_result,
    output in_ready, out_data, out_valid,
    output core_a, core_b, core_issue, occupancy
  );

  modport master (
    output in_a, in_b, in_valid, out_ready, core_result,
    input  in_ready, out_data, out_valid,
    input  core_a, core_b, core_issue, occupancy
  );
endinterface

// File: rtl/li_credit_pipe_wrapper.sv
// Credit-based ready/valid wrapper around a fixed-latency core.
// The core never stalls; results land in a FIFO sized by credits.
module li_credit_pipe_wrapper #(
  parameter int WIDTH   = 32,
  parameter int LATENCY = 3,
  parameter int DEPTH   = 8
) (
  input logic clk,
  input logic reset_n,
  li_credit_pipe_wrapper_if.slave bus
);

  localparam int OW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [OW-1:0] DEPTH_C = OW'(DEPTH);
  localparam logic [PW-1:0] LAST_C  = PW'(DEPTH - 1);

  logic             in_ready_q, in_ready_d;
  logic [OW-1:0]    occ_q, occ_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             issue_q;
  logic             capture;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_q, wr_d;
  logic [PW-1:0]    rd_q, rd_d;
  logic [OW-1:0]    cnt_q, cnt_d;

  logic accept;
  logic deliver;
  logic nonempty;

  function automatic logic [PW-1:0] inc(
    input logic [PW-1:0] p
  );
    return (p == LAST_C) ? '0 : p + PW'(1);
  endfunction

  assign nonempty = (cnt_q != '0);
  assign accept   = bus.in_valid && in_ready_q;
  assign deliver  = nonempty && bus.out_ready;

  // capture marks the cycle core_result belongs to a live pair
  if (LATENCY == 0) begin : g_comb
    assign capture = issue_q;
  end else begin : g_shift
    logic [LATENCY-1:0] sh_q, sh_d;

    if (LATENCY == 1) begin : g_one
      assign sh_d = issue_q;
    end else begin : g_many
      assign sh_d = {sh_q[LATENCY-2:0], issue_q};
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        sh_q <= '0;
      end else begin
        sh_q <= sh_d;
      end
    end

    assign capture = sh_q[LATENCY-1];
  end

  always_comb begin
    occ_d      = occ_q + OW'(accept) - OW'(deliver);
    in_ready_d = (occ_d < DEPTH_C);
    a_d        = a_q;
    b_d        = b_q;
    if (accept) begin
      a_d = bus.in_a;
      b_d = bus.in_b;
    end
    wr_d  = capture ? inc(wr_q) : wr_q;
    rd_d  = deliver ? inc(rd_q) : rd_q;
    cnt_d = cnt_q + OW'(capture) - OW'(deliver);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      in_ready_q <= 1'b0;
      occ_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      issue_q    <= 1'b0;
      wr_q       <= '0;
      rd_q       <= '0;
      cnt_q      <= '0;
    end else begin
      in_ready_q <= in_ready_d;
      occ_q      <= occ_d;
      a_q        <= a_d;
      b_q        <= b_d;
      issue_q    <= accept;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      cnt_q      <= cnt_d;
    end
  end

  // storage is cleared so out_data reads 0 out of reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (capture) begin
      mem_q[wr_q] <= bus.core_result;
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.out_valid  = nonempty;
  assign bus.out_data   = mem_q[rd_q];
  assign bus.core_a     = a_q;
  assign bus.core_b     = b_q;
  assign bus.core_issue = issue_q;
  assign bus.occupancy  = occ_q;

endmodule

// File: tb/tb_li_credit_pipe_wrapper.sv
// Bench for li_credit_pipe_wrapper: three configurations,
// adder core models and per-instance scoreboards.
module tb_li_credit_pipe_wrapper;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  li_credit_pipe_wrapper_if #(.WIDTH(32), .DEPTH(8)) if0 ();
  li_credit_pipe_wrapper_if #(.WIDTH(32), .DEPTH(4)) if1 ();
  li_credit_pipe_wrapper_if #(.WIDTH(32), .DEPTH(5)) if2 ();

  li_credit_pipe_wrapper #(.WIDTH(32), .LATENCY(3), .DEPTH(8)) u0 (
    .clk(clk), .reset_n(reset_n), .bus(if0));
  li_credit_pipe_wrapper #(.WIDTH(32), .LATENCY(3), .DEPTH(4)) u1 (
    .clk(clk), .reset_n(reset_n), .bus(if1));
  li_credit_pipe_wrapper #(.WIDTH(32), .LATENCY(2), .DEPTH(5)) u2 (
    .clk(clk), .reset_n(reset_n), .bus(if2));

  // adder core models: LATENCY-stage delay of core_a + core_b
  logic [31:0] p0 [3];
  logic [31:0] p1 [3];
  logic [31:0] p2 [2];

  always @(posedge clk) begin
    p0[0] <= if0.core_a + if0.core_b;
    p0[1] <= p0[0];
    p0[2] <= p0[1];
    p1[0] <= if1.core_a + if1.core_b;
    p1[1] <= p1[0];
    p1[2] <= p1[1];
    p2[0] <= if2.core_a + if2.core_b;
    p2[1] <= p2[0];
  end

  assign if0.core_result = p0[2];
  assign if1.core_result = p1[2];
  assign if2.core_result = p2[1];

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic stale(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: got delivery want none (queue empty)", nm);
  endtask

  logic [31:0] sbq0[$];
  logic [31:0] sbq1[$];
  logic [31:0] sbq2[$];
  int dlv0 = 0, dlv1 = 0, dlv2 = 0, push2 = 0;
  int run0 = 0, max0 = 0;
  logic hv0 = 0, hv2 = 0;
  logic [31:0] hd0, hd2;

  initial forever begin
    @(negedge clk);
    if (!reset_n) begin
      sbq0.delete();
      hv0 = 1'b0;
      run0 = 0;
    end else begin
      if (if0.in_valid && if0.in_ready)
        sbq0.push_back(if0.in_a + if0.in_b);
      if (hv0) begin
        chk("hold_valid0", if0.out_valid, 1'b1);
        chk("hold_data0", if0.out_data, hd0);
      end
      hv0 = if0.out_valid && !if0.out_ready;
      hd0 = if0.out_data;
      if (if0.out_valid && if0.out_ready) begin
        dlv0++;
        run0++;
        if (run0 > max0) max0 = run0;
        if (sbq0.size() == 0) stale("stale0");
        else chk("order0", if0.out_data, sbq0.pop_front());
      end else begin
        run0 = 0;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (!reset_n) begin
      sbq1.delete();
    end else begin
      if (if1.in_valid && if1.in_ready)
        sbq1.push_back(if1.in_a + if1.in_b);
      if (if1.out_valid && if1.out_ready) begin
        dlv1++;
        if (sbq1.size() == 0) stale("stale1");
        else chk("order1", if1.out_data, sbq1.pop_front());
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (!reset_n) begin
      sbq2.delete();
      hv2 = 1'b0;
    end else begin
      if (if2.in_valid && if2.in_ready) begin
        sbq2.push_back(if2.in_a + if2.in_b);
        push2++;
      end
      if (hv2) begin
        chk("hold_valid2", if2.out_valid, 1'b1);
        chk("hold_data2", if2.out_data, hd2);
      end
      hv2 = if2.out_valid && !if2.out_ready;
      hd2 = if2.out_data;
      if (if2.out_valid && if2.out_ready) begin
        dlv2++;
        if (sbq2.size() == 0) stale("stale2");
        else chk("order2", if2.out_data, sbq2.pop_front());
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] sum;
  } vec_t;

  vec_t tv [6];
  int acc, cyc, drops, base, cnt, occmax, run, maxrun;
  logic [31:0] got;

  initial begin
    tv[0] = '{32'd5,        32'd7,        32'd12};
    tv[1] = '{32'd0,        32'd0,        32'd0};
    tv[2] = '{32'hFFFFFFFF, 32'd1,        32'd0};
    tv[3] = '{32'h80000000, 32'h80000000, 32'd0};
    tv[4] = '{32'd1234,     32'd4321,     32'd5555};
    tv[5] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE};

    reset_n = 1'b0;
    if0.in_valid = 0; if0.in_a = 0; if0.in_b = 0; if0.out_ready = 1;
    if1.in_valid = 0; if1.in_a = 0; if1.in_b = 0; if1.out_ready = 1;
    if2.in_valid = 0; if2.in_a = 0; if2.in_b = 0; if2.out_ready = 1;

    @(posedge clk); #1;
    chk("rst_in_ready", if0.in_ready, 0);
    chk("rst_out_valid", if0.out_valid, 0);
    chk("rst_out_data", if0.out_data, 0);
    chk("rst_core_a", if0.core_a, 0);
    chk("rst_core_b", if0.core_b, 0);
    chk("rst_core_issue", if0.core_issue, 0);
    chk("rst_occupancy", if0.occupancy, 0);
    @(negedge clk) reset_n = 1'b1;
    repeat (2) @(posedge clk);

    // single-op latency table, L=3 D=8
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if0.in_a = tv[i].a;
      if0.in_b = tv[i].b;
      if0.in_valid = 1'b1;
      @(negedge clk);
      chk("t1_ready", if0.in_ready, 1);
      for (int c = 1; c <= 6; c++) begin
        @(posedge clk); #1;
        if (c == 1) if0.in_valid = 1'b0;
        @(negedge clk);
        chk("t1_occ", if0.occupancy, (c <= 5) ? 1 : 0);
        chk("t1_valid", if0.out_valid, c == 5);
        if (c == 1) begin
          chk("t1_issue", if0.core_issue, 1);
          chk("t1_core_a", if0.core_a, tv[i].a);
          chk("t1_core_b", if0.core_b, tv[i].b);
        end
        if (c == 2) begin
          chk("t1_issue_off", if0.core_issue, 0);
          chk("t1_core_hold", if0.core_a, tv[i].a);
        end
        if (c == 5) chk("t1_data", if0.out_data, tv[i].sum);
      end
    end

    // streaming 32 pairs
    max0 = 0; drops = 0; base = dlv0;
    for (int i = 0; i < 32; i++) begin
      @(posedge clk); #1;
      if0.in_a = i; if0.in_b = 100; if0.in_valid = 1'b1;
      @(negedge clk);
      if (!if0.in_ready) drops++;
    end
    @(posedge clk); #1 if0.in_valid = 1'b0;
    for (int k = 0; k < 20 && dlv0 < base + 32; k++) @(negedge clk);
    @(negedge clk);
    chk("t2_drops", drops, 0);
    chk("t2_count", dlv0 - base, 32);
    chk("t2_run", max0, 32);

    // stall with out_ready low, then drain
    @(posedge clk); #1 if0.out_ready = 1'b0;
    acc = 0;
    for (int k = 0; k < 16; k++) begin
      @(posedge clk); #1;
      if0.in_a = k + 1; if0.in_b = 1000; if0.in_valid = 1'b1;
      @(negedge clk);
      if (if0.in_ready) acc++;
    end
    @(posedge clk); #1 if0.in_valid = 1'b0;
    @(negedge clk);
    chk("t3_accepts", acc, 8);
    chk("t3_ready_low", if0.in_ready, 0);
    chk("t3_occ_full", if0.occupancy, 8);
    chk("t3_valid", if0.out_valid, 1);
    @(posedge clk); #1 if0.out_ready = 1'b1;
    @(negedge clk);
    chk("t3_ready_d0", if0.in_ready, 0);
    @(negedge clk);
    chk("t3_ready_d1", if0.in_ready, 1);
    for (int k = 0; k < 20 && sbq0.size() != 0; k++) @(negedge clk);
    @(negedge clk);
    chk("t3_left", sbq0.size(), 0);
    chk("t3_occ_zero", if0.occupancy, 0);

    // async reset with 3 pairs in the core and 2 in the FIFO
    @(posedge clk); #1 if0.out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      if0.in_a = 200 + k; if0.in_b = 1; if0.in_valid = 1'b1;
    end
    @(posedge clk); #1 if0.in_valid = 1'b0;
    @(posedge clk); #2;
    chk("t5_occ_pre", if0.occupancy, 5);
    chk("t5_valid_pre", if0.out_valid, 1);
    #1 reset_n = 1'b0;
    #1;
    chk("t5_out_valid", if0.out_valid, 0);
    chk("t5_in_ready", if0.in_ready, 0);
    chk("t5_occ", if0.occupancy, 0);
    chk("t5_out_data", if0.out_data, 0);
    chk("t5_issue", if0.core_issue, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    if0.out_ready = 1'b1;
    cnt = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (if0.out_valid) cnt++;
    end
    chk("t5_no_stale", cnt, 0);
    @(posedge clk); #1;
    if0.in_a = 9; if0.in_b = 10; if0.in_valid = 1'b1;
    @(posedge clk); #1 if0.in_valid = 1'b0;
    got = 0; base = dlv0;
    for (int k = 0; k < 10 && dlv0 == base; k++) begin
      @(negedge clk);
      if (if0.out_valid) got = if0.out_data;
    end
    @(negedge clk);
    chk("t5_new_count", dlv0 - base, 1);
    chk("t5_new_data", got, 19);

    // undersized FIFO, L=3 D=4
    acc = 0; cyc = 0; occmax = 0; run = 0; maxrun = 0;
    while (acc < 20 && cyc < 200) begin
      @(posedge clk); #1;
      if1.in_a = 300 + acc; if1.in_b = acc; if1.in_valid = 1'b1;
      @(negedge clk);
      cyc++;
      if (int'(if1.occupancy) > occmax) occmax = if1.occupancy;
      if (if1.in_ready) begin
        acc++;
        run++;
        if (run > maxrun) maxrun = run;
      end else begin
        run = 0;
      end
    end
    @(posedge clk); #1 if1.in_valid = 1'b0;
    for (int k = 0; k < 30 && sbq1.size() != 0; k++) @(negedge clk);
    @(negedge clk);
    chk("t4_accepts", acc, 20);
    chk("t4_occ_max", occmax, 4);
    chk("t4_ready_run", maxrun, 4);
    chk("t4_delivered", dlv1, 20);
    chk("t4_left", sbq1.size(), 0);

    // random traffic through a non-power-of-two FIFO, L=2 D=5
    acc = 0; cyc = 0;
    while (acc < 50 && cyc < 2000) begin
      @(posedge clk); #1;
      if2.in_valid = 1'($urandom_range(0, 1));
      if2.in_a = $urandom;
      if2.in_b = $urandom;
      if2.out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      cyc++;
      if (if2.in_valid && if2.in_ready) acc++;
    end
    @(posedge clk); #1;
    if2.out_ready = 1'b0; if2.in_valid = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1 if2.in_a = $urandom;
    end
    @(negedge clk);
    chk("t6_full_occ", if2.occupancy, 5);
    @(posedge clk); #1 if2.out_ready = 1'b1;
    for (int k = 0; k < 15; k++) begin
      @(posedge clk); #1 if2.in_b = $urandom;
    end
    if2.in_valid = 1'b0;
    for (int k = 0; k < 40 && sbq2.size() != 0; k++) @(negedge clk);
    @(negedge clk);
    chk("t6_accepts", acc, 50);
    chk("t6_left", sbq2.size(), 0);
    chk("t6_occ_zero", if2.occupancy, 0);
    chk("t6_delivered", dlv2, push2);
    chk("t6_wrapped", dlv2 > 60, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
